mem_responder: RTL



---
 rtl/mem_responder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: 256 x 16 storage with two 2-stage read pipelines (fetch and
// load), one store port, a saturating store counter and an optional store
// snoop port. Optional feature macro: MEM_RESP_SNOOP_EN (snoop registers are
// built only when defined; otherwise snoop_valid/snoop_addr are tied to 0).

// One read lane: S1 captures index and array data, S2 is the output register.
// Stores are forwarded into both the S1 capture and the S1->S2 transfer, so a
// read sampled at edge E sees every store sampled at edges <= E+1.
module mem_responder_rd_lane #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_i,
   input  logic [ADDR_W-1:0] idx_i,
   input  logic [DATA_W-1:0] mem_rd_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_idx_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic              vld_o,
   output logic [DATA_W-1:0] data_o
);

   // vld_pipe[1] is S1 valid, vld_pipe[2] is S2 (output) valid
   logic [2:1]        vld_pipe_d, vld_pipe_q;
   logic [ADDR_W-1:0] s1_idx_d, s1_idx_q;
   logic [DATA_W-1:0] s1_data_d, s1_data_q;
   logic [DATA_W-1:0] s2_data_d, s2_data_q;

   // next-state for both stages, with store forwarding
   always_comb begin
      vld_pipe_d = {vld_pipe_q[1], req_i};
      s1_idx_d   = s1_idx_q;
      s1_data_d  = s1_data_q;
      s2_data_d  = s2_data_q;
      if (req_i) begin
         s1_idx_d  = idx_i;
         s1_data_d = (wr_en_i && (wr_idx_i == idx_i)) ? wr_data_i : mem_rd_i;
      end
      if (vld_pipe_q[1]) begin
         s2_data_d = (wr_en_i && (wr_idx_i == s1_idx_q)) ? wr_data_i : s1_data_q;
      end
   end

   // pipeline registers; reset clears valids and data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe_q <= '0;
         s1_idx_q   <= '0;
         s1_data_q  <= '0;
         s2_data_q  <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         s1_idx_q   <= s1_idx_d;
         s1_data_q  <= s1_data_d;
         s2_data_q  <= s2_data_d;
      end
   end

   assign vld_o  = vld_pipe_q[2];
   assign data_o = s2_data_q;

endmodule

module mem_responder #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       fetch_addr,
   output logic [DATA_W-1:0] fetch_data,
   output logic              fetch_valid,
   input  logic              ld_req,
   input  logic [15:0]       ld_addr,
   output logic [DATA_W-1:0] ld_data,
   output logic              ld_valid,
   input  logic              wr_en,
   input  logic [15:0]       wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              snoop_valid,
   output logic [15:0]       snoop_addr,
   output logic [15:0]       wr_count
);

   localparam int NUM_LANES = 2;   // lane 0 = fetch, lane 1 = load
   localparam int DEPTH     = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [ADDR_W-1:0]                 wr_idx;
   logic [NUM_LANES-1:0]              rd_req;
   logic [NUM_LANES-1:0][ADDR_W-1:0]  rd_idx;
   logic [NUM_LANES-1:0][DATA_W-1:0]  rd_mem;
   logic [NUM_LANES-1:0]              rd_vld;
   logic [NUM_LANES-1:0][DATA_W-1:0]  rd_data;
   logic [15:0]                       wr_count_d, wr_count_q;

   // upper address bits alias onto the array (index = addr mod depth)
   logic unused_addr_hi;
   assign unused_addr_hi = ^{fetch_addr, ld_addr, wr_addr};

   assign wr_idx    = wr_addr[ADDR_W-1:0];
   assign rd_req[0] = 1'b1;
   assign rd_idx[0] = fetch_addr[ADDR_W-1:0];
   assign rd_req[1] = ld_req;
   assign rd_idx[1] = ld_addr[ADDR_W-1:0];

   // array write; contents survive reset and writes during reset are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
      end else if (wr_en) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

   generate
      for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
         assign rd_mem[g] = mem_q[rd_idx[g]];
         mem_responder_rd_lane #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
         ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_i     (rd_req[g]),
            .idx_i     (rd_idx[g]),
            .mem_rd_i  (rd_mem[g]),
            .wr_en_i   (wr_en),
            .wr_idx_i  (wr_idx),
            .wr_data_i (wr_data),
            .vld_o     (rd_vld[g]),
            .data_o    (rd_data[g])
         );
      end
   endgenerate

   assign fetch_valid = rd_vld[0];
   assign fetch_data  = rd_data[0];
   assign ld_valid    = rd_vld[1];
   assign ld_data     = rd_data[1];

   // store counter saturates at all-ones
   always_comb begin
      wr_count_d = wr_count_q;
      if (wr_en && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
   end

   // store counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wr_count_q <= '0;
      else        wr_count_q <= wr_count_d;
   end

   assign wr_count = wr_count_q;

`ifdef MEM_RESP_SNOOP_EN
   logic        snoop_valid_d, snoop_valid_q;
   logic [15:0] snoop_addr_d, snoop_addr_q;

   // snoop pulse one cycle after each committed store
   always_comb begin
      snoop_valid_d = wr_en;
      snoop_addr_d  = snoop_addr_q;
      if (wr_en) snoop_addr_d = {{(16-ADDR_W){1'b0}}, wr_idx};
   end

   // snoop registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snoop_valid_q <= 1'b0;
         snoop_addr_q  <= '0;
      end else begin
         snoop_valid_q <= snoop_valid_d;
         snoop_addr_q  <= snoop_addr_d;
      end
   end

   assign snoop_valid = snoop_valid_q;
   assign snoop_addr  = snoop_addr_q;
`else
   assign snoop_valid = 1'b0;
   assign snoop_addr  = '0;
`endif

endmodule
